// File: rtl/param_queue_pkg.sv
// Shared defaults and pointer helper for the parametrised circular-buffer queue.
package param_queue_pkg;

   localparam int QUEUE_WIDTH_DEF = 8;
   localparam int QUEUE_DEPTH_DEF = 8;

   // Explicit wrap so non-power-of-two depths never rely on counter overflow.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/param_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module param_queue_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int PW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are intentionally not reset; occupancy tracking makes stale words unreachable.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_queue.sv
// Parametrised FIFO with registered dequeue data and per-request ack pulses.
// Optional sticky overflow/underflow flags when PARAM_QUEUE_ERR_EN is defined.
module param_queue
   import param_queue_pkg::*;
#(
   parameter  int WIDTH     = QUEUE_WIDTH_DEF,
   parameter  int DEPTH     = QUEUE_DEPTH_DEF,
   parameter  int AFULL_LVL = DEPTH - 1,
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int PW        = $clog2(DEPTH)
) (
   input  logic             clk_10khz,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             enqueue_in,
   input  logic             dequeue_in,
   output logic             ack_in,
   output logic             deq_ack_out,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    len_out,
   output logic             full_out,
   output logic             empty_out,
`ifdef PARAM_QUEUE_ERR_EN
   output logic             overflow_out,
   output logic             underflow_out,
`endif
   output logic             afull_out
);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ack_q, ack_d;
   logic             deq_ack_q, deq_ack_d;
   logic             enq_ok, deq_ok;
   logic [WIDTH-1:0] rd_word;

   param_queue_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk   (clk_10khz),
      .we    (enq_ok),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (rd_word)
   );

   always_comb begin
      deq_ok    = dequeue_in && (count_q != '0);
      // A dequeue in the same cycle frees the slot, so a full queue still accepts.
      enq_ok    = enqueue_in && ((count_q != CW'(DEPTH)) || deq_ok);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      data_d    = data_q;
      ack_d     = enq_ok;
      deq_ack_d = deq_ok;
      if (enq_ok) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      if (deq_ok) begin
         rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
         data_d   = rd_word;
      end
      if (enq_ok && !deq_ok) count_d = count_q + CW'(1);
      if (deq_ok && !enq_ok) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_10khz) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         data_q    <= '0;
         ack_q     <= 1'b0;
         deq_ack_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         deq_ack_q <= deq_ack_d;
      end
   end

`ifdef PARAM_QUEUE_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (enqueue_in & ~enq_ok);
      unf_d = unf_q | (dequeue_in & ~deq_ok);
   end

   always_ff @(posedge clk_10khz) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow_out  = ovf_q;
   assign underflow_out = unf_q;
`endif

   assign ack_in      = ack_q;
   assign deq_ack_out = deq_ack_q;
   assign data_out    = data_q;
   assign len_out     = count_q;
   assign full_out    = (count_q == CW'(DEPTH));
   assign empty_out   = (count_q == '0);
   assign afull_out   = (count_q >= CW'(AFULL_LVL));

endmodule

// File: tb/tb_param_queue.sv
// Self-checking bench: directed vector table on DEPTH=8, random run against a
// queue model, DEPTH=5 wrap-around stream, and mid-operation reset.
module tb_param_queue;

   logic       clk;
   logic       reset;
   logic [7:0] din8, dout8;
   logic       enq8, deq8, ack8, dack8, full8, empty8, afull8;
   logic [3:0] len8;
   logic [7:0] din5, dout5;
   logic       enq5, deq5, ack5, dack5, full5, empty5, afull5;
   logic [2:0] len5;
`ifdef PARAM_QUEUE_ERR_EN
   logic       ovf8, unf8, ovf5, unf5;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #50 clk = ~clk;

   param_queue #(.WIDTH(8), .DEPTH(8)) u_dut8 (
      .clk_10khz(clk), .reset(reset), .data_in(din8), .enqueue_in(enq8), .dequeue_in(deq8),
      .ack_in(ack8), .deq_ack_out(dack8), .data_out(dout8), .len_out(len8),
      .full_out(full8), .empty_out(empty8),
`ifdef PARAM_QUEUE_ERR_EN
      .overflow_out(ovf8), .underflow_out(unf8),
`endif
      .afull_out(afull8)
   );

   param_queue #(.WIDTH(8), .DEPTH(5)) u_dut5 (
      .clk_10khz(clk), .reset(reset), .data_in(din5), .enqueue_in(enq5), .dequeue_in(deq5),
      .ack_in(ack5), .deq_ack_out(dack5), .data_out(dout5), .len_out(len5),
      .full_out(full5), .empty_out(empty5),
`ifdef PARAM_QUEUE_ERR_EN
      .overflow_out(ovf5), .underflow_out(unf5),
`endif
      .afull_out(afull5)
   );

   typedef struct {
      logic       enq, deq;
      logic [7:0] din;
      logic       ack, dack;
      logic [7:0] dout;
      int         len;
      logic       full, empty, afull;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic d, input logic [7:0] di, input logic a,
                      input logic da, input logic [7:0] dq, input int l,
                      input logic f, input logic em, input logic af);
      vec_t v;
      v.enq = e; v.deq = d; v.din = di; v.ack = a; v.dack = da; v.dout = dq;
      v.len = l; v.full = f; v.empty = em; v.afull = af;
      vecs.push_back(v);
   endtask

   task automatic step8(input logic e, input logic d, input logic [7:0] di);
      enq8 = e; deq8 = d; din8 = di;
      @(posedge clk); #1;
   endtask

   task automatic chk8(input string tag, input logic a, input logic da, input logic [7:0] dq,
                       input int l, input logic f, input logic em, input logic af);
      chk({tag, " ack"},   32'(ack8),   32'(a));
      chk({tag, " dack"},  32'(dack8),  32'(da));
      chk({tag, " dout"},  32'(dout8),  32'(dq));
      chk({tag, " len"},   32'(len8),   32'(l));
      chk({tag, " full"},  32'(full8),  32'(f));
      chk({tag, " empty"}, 32'(empty8), 32'(em));
      chk({tag, " afull"}, 32'(afull8), 32'(af));
   endtask

   initial begin
      logic [7:0] q8[$];
      logic [7:0] q5[$];
      logic [7:0] sent5[$];
      logic [7:0] got5[$];
      logic [7:0] m_dout, w;
      logic       e, d, dok, eok;
      int         nsent;

      reset = 1'b1; enq8 = 0; deq8 = 0; din8 = 0; enq5 = 0; deq5 = 0; din5 = 0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      chk8("reset", 0, 0, 8'h00, 0, 0, 1, 0);
`ifdef PARAM_QUEUE_ERR_EN
      chk("reset ovf", 32'(ovf8), 0);
      chk("reset unf", 32'(unf8), 0);
`endif

      // enq, deq, din | ack, dack, dout, len, full, empty, afull
      add(1, 0, 8'h11, 1, 0, 8'h00, 1, 0, 0, 0);
      add(1, 0, 8'h22, 1, 0, 8'h00, 2, 0, 0, 0);
      add(1, 0, 8'h33, 1, 0, 8'h00, 3, 0, 0, 0);
      add(0, 1, 8'h00, 0, 1, 8'h11, 2, 0, 0, 0);
      add(0, 1, 8'h00, 0, 1, 8'h22, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 1, 8'h33, 0, 0, 1, 0);
      add(0, 0, 8'h00, 0, 0, 8'h33, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++)
         add(1, 0, 8'hA0 + 8'(i), 1, 0, 8'h33, i + 1, i == 7, 0, i >= 6);
      add(1, 0, 8'hFF, 0, 0, 8'h33, 8, 1, 0, 1);
      add(1, 1, 8'hB0, 1, 1, 8'hA0, 8, 1, 0, 1);
      for (int i = 0; i < 7; i++)
         add(0, 1, 8'h00, 0, 1, 8'hA1 + 8'(i), 7 - i, 0, 0, i == 0);
      add(0, 1, 8'h00, 0, 1, 8'hB0, 0, 0, 1, 0);
      add(1, 1, 8'h5C, 1, 0, 8'hB0, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 1, 8'h5C, 0, 0, 1, 0);

      foreach (vecs[i]) begin
         step8(vecs[i].enq, vecs[i].deq, vecs[i].din);
         chk8($sformatf("vec%0d", i), vecs[i].ack, vecs[i].dack, vecs[i].dout,
              vecs[i].len, vecs[i].full, vecs[i].empty, vecs[i].afull);
      end
`ifdef PARAM_QUEUE_ERR_EN
      chk("sticky ovf", 32'(ovf8), 1);
      chk("sticky unf", 32'(unf8), 1);
`endif

      // Random traffic against a plain FIFO model.
      m_dout = 8'h5C;
      for (int c = 0; c < 300; c++) begin
         e = 1'($urandom_range(0, 99) < 55);
         d = 1'($urandom_range(0, 99) < 45);
         w = 8'($urandom);
         dok = d && (q8.size() > 0);
         eok = e && (q8.size() < 8 || dok);
         if (dok) m_dout = q8.pop_front();
         if (eok) q8.push_back(w);
         step8(e, d, w);
         chk8($sformatf("rnd%0d", c), eok, dok, m_dout, q8.size(),
              q8.size() == 8, q8.size() == 0, q8.size() >= 7);
      end
      enq8 = 0; deq8 = 0;

      // DEPTH=5 stream of 20 words with occupancy held in 1..5.
      nsent = 0;
      for (int c = 0; c < 400 && (nsent < 20 || q5.size() > 0); c++) begin
         e = (nsent < 20) && 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         if (nsent < 20 && q5.size() <= 1) d = 1'b0;
         if (q5.size() == 5 && !d) e = 1'b0;
         if (nsent == 20) begin e = 1'b0; d = 1'b1; end
         w = 8'($urandom);
         dok = d && (q5.size() > 0);
         eok = e && (q5.size() < 5 || dok);
         if (dok) void'(q5.pop_front());
         if (eok) begin q5.push_back(w); sent5.push_back(w); nsent++; end
         enq5 = e; deq5 = d; din5 = w;
         @(posedge clk); #1;
         if (dack5) got5.push_back(dout5);
         chk($sformatf("d5 len%0d", c), 32'(len5), 32'(q5.size()));
         chk($sformatf("d5 ack%0d", c), 32'(ack5), 32'(eok));
         if (len5 > 3'd5) begin
            n_fail++;
            $display("FAIL d5 len bound: got %0d required <= 5", len5);
         end
      end
      enq5 = 0; deq5 = 0;
      chk("d5 sent", 32'(sent5.size()), 20);
      chk("d5 got", 32'(got5.size()), 20);
      foreach (got5[i])
         if (i < sent5.size()) chk($sformatf("d5 order%0d", i), 32'(got5[i]), 32'(sent5[i]));

      // Reset with len=4 and both requests high.
      reset = 1'b1; step8(0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step8(1, 0, 8'h40 + 8'(i));
      chk("pre-reset len", 32'(len8), 4);
      reset = 1'b1;
      step8(1, 1, 8'h77);
      chk8("midreset", 0, 0, 8'h00, 0, 0, 1, 0);
`ifdef PARAM_QUEUE_ERR_EN
      chk("midreset ovf", 32'(ovf8), 0);
      chk("midreset unf", 32'(unf8), 0);
`endif
      reset = 1'b0;
      step8(0, 0, 0);
      chk8("postreset", 0, 0, 8'h00, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/param_queue.md
# param_queue

Parametrised circular-buffer FIFO, successor to the fixed 8×8-bit queue used in the multi-clock demo datapath. Storage width, depth and almost-full threshold are set by parameters. Output ordering is strict first-in-first-out. Simultaneous enqueue/dequeue is accepted at full occupancy, and dequeues return a registered data word with its own acknowledge. The block sits in the slow `clk_10khz` domain between the input sampler and the display/consumer logic.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries (≥2; need not be a power of two)
- `AFULL_LVL`, DEPTH-1, occupancy at or above which `afull_out` asserts (1..DEPTH)
- `clk_10khz`  in  1  sole clock; all state on rising edge
- `reset`  in  1  synchronous, active-high; clears all state at the next edge
- `data_in`  in  WIDTH  word to insert
- `enqueue_in`  in  1  insert request, sampled every edge
- `dequeue_in`  in  1  remove request, sampled every edge
- `ack_in`  out  1  registered pulse: enqueue accepted at the previous edge
- `deq_ack_out`  out  1  registered pulse: `data_out` was updated at the previous edge
- `data_out`  out  WIDTH  last removed word, held until the next accepted dequeue
- `len_out`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- `full_out`, `empty_out`, `afull_out`  out  1 each  decoded from the occupancy register
- `overflow_out`, `underflow_out`  out  1 each  present only with `PARAM_QUEUE_ERR_EN`

## Operation
- Storage: DEPTH×WIDTH array with write pointer `wr_ptr`, read pointer `rd_ptr` and count register `count`.
- Pointers increment modulo DEPTH. The wrap from DEPTH-1 to 0 is explicit, so pointer arithmetic never depends on power-of-two overflow.
- Dequeue accept rule: `deq_ok = dequeue_in && count != 0`.
- Enqueue accept rule: `enq_ok = enqueue_in && (count != DEPTH || deq_ok)`. When full, a simultaneous dequeue frees a slot, so both are accepted.
- Empty with both requests: dequeue rejected, enqueue accepted. No bypass: `data_out` keeps its old value and `deq_ack_out` stays 0.
- Count update: +1 on enq_ok only, −1 on deq_ok only, unchanged when both or neither are accepted.
- On deq_ok: `data_out <= mem[rd_ptr]`, then `rd_ptr` advances.
- On enq_ok: `mem[wr_ptr] <= data_in`, then `wr_ptr` advances.
- Rejected requests leave all state unchanged apart from the ack pulses, which go to 0.
- Flags: `full_out = (count == DEPTH)`, `empty_out = (count == 0)`, `afull_out = (count >= AFULL_LVL)`.
- Reset clears pointers, count, `data_out`, `ack_in`, `deq_ack_out` and the error flags. Memory contents are not cleared.

## Timing
- Reset values: `data_out` = 0, `len_out` = 0, `ack_in` = 0, `deq_ack_out` = 0, `full_out` = 0, `empty_out` = 1, `afull_out` = 0, `overflow_out` = 0, `underflow_out` = 0.
- Reset asserted mid-operation wins over any request at that edge. Requests sampled during reset are dropped, not acknowledged.
- Enqueue latency: data is sampled at edge N, `ack_in` = 1 and `len_out` updated after edge N.
- Earliest dequeue of that word: edge N+1, with `data_out` valid after edge N+1.
- `ack_in` and `deq_ack_out` are single-cycle pulses per accepted request. They stay high across consecutive edges when requests are accepted back-to-back.
- Requests are level-sampled with no handshake hold requirement. Holding `enqueue_in` high inserts once per edge until full.
- Flags are combinational decodes of the `count` register, so they add no latency beyond `len_out`.

## Configuration
- `PARAM_QUEUE_ERR_EN` defined: adds the `overflow_out` and `underflow_out` ports.
  - `overflow_out` sets on any edge with `enqueue_in` high and enq_ok low.
  - `underflow_out` sets on any edge with `dequeue_in` high and deq_ok low.
  - Both flags are sticky until `reset`.
- Macro undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Package `param_queue_pkg`:
  - constant defaults (`QUEUE_WIDTH_DEF = 8`, `QUEUE_DEPTH_DEF = 8`)
  - function `ptr_inc(ptr, depth)` implementing the modulo-DEPTH increment
- Sub-module `param_queue_mem`: DEPTH×WIDTH register array.
  - One write port: `we`, `waddr`, `wdata`.
  - One asynchronous read port: `raddr`, `rdata`.
- Top level holds the pointers, count, accept logic, flags and output registers.

## Test plan
- WIDTH=8, DEPTH=8: reset, then enqueue 0x11, 0x22, 0x33 on consecutive edges → `ack_in` high 3 cycles, `len_out` 1→2→3. Three dequeues → `data_out` 0x11, 0x22, 0x33 in order, `deq_ack_out` high 3 cycles, `empty_out` = 1.
- Fill with 0xA0..0xA7 → `full_out` = 1, `afull_out` = 1 from `len_out` = 7. Ninth enqueue (0xFF) → `ack_in` = 0, `len_out` stays 8, and with the macro `overflow_out` = 1.
- Full queue, enqueue 0xB0 with dequeue in the same cycle → `data_out` = 0xA0, both acks = 1, `len_out` = 8. Eight further dequeues yield 0xA1..0xA7, 0xB0.
- Empty queue, enqueue 0x5C with dequeue in the same cycle → `ack_in` = 1, `deq_ack_out` = 0, `data_out` unchanged, `len_out` = 1; with the macro `underflow_out` = 1.
- Wrap-around with DEPTH=5: stream 20 words, keeping occupancy between 1 and 5 → output order matches input order exactly and `len_out` never exceeds 5.
- `reset` asserted with `len_out` = 4 and both requests high → the next cycle shows all reset values, `empty_out` = 1, and no ack pulses.
